fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit.sv | 160 ++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Shadow EX/MEM/WB pipeline tracker producing EX operand
//               forwarding selects, a load-use stall and a saturating count
//               of stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
    // Value at which stall_count stops incrementing
    parameter logic [15:0] STALL_SAT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_dest,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        flush,
    output logic [1:0]  forward_a,
    output logic [1:0]  forward_b,
    output logic        stall,
    output logic [15:0] stall_count
);

    localparam logic [1:0] c_FWD_NONE = 2'b00;
    localparam logic [1:0] c_FWD_WB   = 2'b01;
    localparam logic [1:0] c_FWD_MEM  = 2'b10;

    // EX stage shadow state
    logic        r_ex_valid;
    logic [4:0]  r_ex_rs;
    logic [4:0]  r_ex_rt;
    logic        r_ex_uses_rt;
    logic [4:0]  r_ex_dest;
    logic        r_ex_regwrite;
    logic        r_ex_memread;

    // MEM stage shadow state
    logic        r_mem_valid;
    logic [4:0]  r_mem_dest;
    logic        r_mem_regwrite;
    logic        r_mem_memread;

    // WB stage shadow state
    logic        r_wb_valid;
    logic [4:0]  r_wb_dest;
    logic        r_wb_regwrite;

    logic [15:0] r_stall_count;

    logic        w_mem_writer;
    logic        w_wb_writer;
    logic        w_stall;
    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;

    // A stage is a usable forwarding source only if it really writes a
    // non-zero register; r0 is hardwired and must never be forwarded.
    assign w_mem_writer = r_mem_valid && r_mem_regwrite && (r_mem_dest != 5'd0);
    assign w_wb_writer  = r_wb_valid  && r_wb_regwrite  && (r_wb_dest  != 5'd0);

    // Load-use hazard: a load in EX whose result the ID instruction needs.
    // Flush wins, since the squashed ID instruction will never execute.
    assign w_stall = !flush && id_valid
                  && r_ex_valid && r_ex_memread && r_ex_regwrite
                  && (r_ex_dest != 5'd0)
                  && ((r_ex_dest == id_rs) || (id_uses_rt && (r_ex_dest == id_rt)));

    // Forwarding selects from registered state only; MEM beats WB because it
    // holds the younger write to the same register.
    always_comb begin
        w_fwd_a = c_FWD_NONE;
        w_fwd_b = c_FWD_NONE;
        if (r_ex_valid) begin
            if (w_mem_writer && (r_mem_dest == r_ex_rs)) begin
                w_fwd_a = c_FWD_MEM;
            end else if (w_wb_writer && (r_wb_dest == r_ex_rs)) begin
                w_fwd_a = c_FWD_WB;
            end
            if (r_ex_uses_rt) begin
                if (w_mem_writer && (r_mem_dest == r_ex_rt)) begin
                    w_fwd_b = c_FWD_MEM;
                end else if (w_wb_writer && (r_wb_dest == r_ex_rt)) begin
                    w_fwd_b = c_FWD_WB;
                end
            end
        end
    end

    // ID->EX load; a flush or stall injects a bubble so the hazard clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_rs       <= 5'd0;
            r_ex_rt       <= 5'd0;
            r_ex_uses_rt  <= 1'b0;
            r_ex_dest     <= 5'd0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
        end else if (flush || w_stall) begin
            r_ex_valid    <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
        end else begin
            r_ex_valid    <= id_valid;
            r_ex_rs       <= id_rs;
            r_ex_rt       <= id_rt;
            r_ex_uses_rt  <= id_uses_rt;
            r_ex_dest     <= id_dest;
            r_ex_regwrite <= id_regwrite;
            r_ex_memread  <= id_memread;
        end
    end

    // EX->MEM and MEM->WB advance every cycle regardless of stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid    <= 1'b0;
            r_mem_dest     <= 5'd0;
            r_mem_regwrite <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_dest      <= 5'd0;
            r_wb_regwrite  <= 1'b0;
        end else begin
            r_mem_valid    <= r_ex_valid;
            r_mem_dest     <= r_ex_dest;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_memread  <= r_ex_memread;
            r_wb_valid     <= r_mem_valid;
            r_wb_dest      <= r_mem_dest;
            r_wb_regwrite  <= r_mem_regwrite;
        end
    end

    // Saturating count of cycles spent stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= 16'd0;
        end else if (w_stall && (r_stall_count != STALL_SAT)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign forward_a   = w_fwd_a;
    assign forward_b   = w_fwd_b;
    assign stall       = w_stall;
    assign stall_count = r_stall_count;

    // MEM-stage load flag is tracked for completeness of the shadow pipe but
    // does not influence any decision once the load has left EX.
    logic w_unused;
    assign w_unused = r_mem_memread;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_unit
// Description : Self-checking bench for fwd_hazard_unit: table of per-cycle
//               ID inputs with expected outputs, scoreboarded, plus directed
//               sequences for async reset and counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [4:0] dest;
        logic       regwrite;
        logic       memread;
        logic       fl;
        logic [1:0] exp_fa;
        logic [1:0] exp_fb;
        logic       exp_stall;
        logic [15:0] exp_cnt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic [4:0]  id_dest;
    logic        id_regwrite;
    logic        id_memread;
    logic        flush;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic        stall;
    logic [15:0] stall_count;

    // Second instance with a low saturation point so saturation is reachable
    logic        s_valid;
    logic [4:0]  s_rs;
    logic [4:0]  s_dest;
    logic        s_memread;
    logic [1:0]  s_fa;
    logic [1:0]  s_fb;
    logic        s_stall;
    logic [15:0] s_count;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];
    vec_t sb[$];
    int   monitor_on = 0;

    fwd_hazard_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .id_dest     (id_dest),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .forward_a   (forward_a),
        .forward_b   (forward_b),
        .stall       (stall),
        .stall_count (stall_count)
    );

    fwd_hazard_unit #(.STALL_SAT(16'd5)) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (s_valid),
        .id_rs       (s_rs),
        .id_rt       (5'd0),
        .id_uses_rt  (1'b0),
        .id_dest     (s_dest),
        .id_regwrite (1'b1),
        .id_memread  (s_memread),
        .flush       (1'b0),
        .forward_a   (s_fa),
        .forward_b   (s_fb),
        .stall       (s_stall),
        .stall_count (s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic ut, input logic [4:0] d, input logic rw,
                           input logic mr, input logic fl, input logic [1:0] fa,
                           input logic [1:0] fb, input logic st, input logic [15:0] cnt);
        vec_t t;
        t.valid = v; t.rs = rs; t.rt = rt; t.uses_rt = ut; t.dest = d;
        t.regwrite = rw; t.memread = mr; t.fl = fl;
        t.exp_fa = fa; t.exp_fb = fb; t.exp_stall = st; t.exp_cnt = cnt;
        vecs.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        id_valid    = t.valid;
        id_rs       = t.rs;
        id_rt       = t.rt;
        id_uses_rt  = t.uses_rt;
        id_dest     = t.dest;
        id_regwrite = t.regwrite;
        id_memread  = t.memread;
        flush       = t.fl;
    endtask

    // Scoreboard consumer: outputs are compared mid-cycle on the falling edge
    always @(negedge clk) begin
        if (monitor_on != 0 && sb.size() > 0) begin
            vec_t e;
            e = sb.pop_front();
            check("forward_a",   {14'd0, forward_a},   {14'd0, e.exp_fa});
            check("forward_b",   {14'd0, forward_b},   {14'd0, e.exp_fb});
            check("stall",       {15'd0, stall},       {15'd0, e.exp_stall});
            check("stall_count", stall_count,          e.exp_cnt);
        end
    end

    initial begin
        vec_t idle;
        idle = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0};
        drive(idle);
        s_valid = 1'b0; s_rs = 5'd0; s_dest = 5'd0; s_memread = 1'b0;
        rst_n = 1'b0;

        //       v  rs     rt     ut  dest   rw mr fl  fa     fb     st  cnt
        add_vec(0, 5'd0,  5'd0,  0, 5'd0,  0, 0, 0, 2'b00, 2'b00, 0, 16'd0); // reset state
        add_vec(1, 5'd1,  5'd2,  1, 5'd3,  1, 0, 0, 2'b00, 2'b00, 0, 16'd0); // add r3
        add_vec(1, 5'd3,  5'd4,  1, 5'd6,  1, 0, 0, 2'b00, 2'b00, 0, 16'd0); // sub uses r3
        add_vec(0, 5'd0,  5'd0,  0, 5'd0,  0, 0, 0, 2'b10, 2'b00, 0, 16'd0); // sub in EX: MEM fwd
        add_vec(1, 5'd1,  5'd1,  1, 5'd5,  1, 0, 0, 2'b00, 2'b00, 0, 16'd0); // add r5
        add_vec(1, 5'd8,  5'd9,  1, 5'd10, 1, 0, 0, 2'b00, 2'b00, 0, 16'd0); // unrelated
        add_vec(1, 5'd11, 5'd5,  1, 5'd12, 1, 0, 0, 2'b00, 2'b00, 0, 16'd0); // or rt=r5
        add_vec(1, 5'd1,  5'd1,  1, 5'd5,  1, 0, 0, 2'b00, 2'b01, 0, 16'd0); // or in EX: WB fwd b
        add_vec(1, 5'd8,  5'd9,  1, 5'd10, 1, 0, 0, 2'b00, 2'b00, 0, 16'd0); // unrelated
        add_vec(1, 5'd11, 5'd5,  0, 5'd12, 1, 0, 0, 2'b00, 2'b00, 0, 16'd0); // rt=r5, uses_rt=0
        add_vec(1, 5'd1,  5'd2,  1, 5'd7,  1, 0, 0, 2'b00, 2'b00, 0, 16'd0); // add r7; uses_rt=0 in EX
        add_vec(1, 5'd1,  5'd2,  1, 5'd7,  1, 0, 0, 2'b00, 2'b00, 0, 16'd0); // add r7 again
        add_vec(1, 5'd7,  5'd13, 1, 5'd14, 1, 0, 0, 2'b00, 2'b00, 0, 16'd0); // and rs=r7
        add_vec(0, 5'd0,  5'd0,  0, 5'd0,  0, 0, 0, 2'b10, 2'b00, 0, 16'd0); // MEM beats WB
        add_vec(1, 5'd1,  5'd4,  0, 5'd4,  1, 1, 0, 2'b00, 2'b00, 0, 16'd0); // lw r4
        add_vec(1, 5'd4,  5'd2,  1, 5'd15, 1, 0, 0, 2'b00, 2'b00, 1, 16'd0); // add rs=r4: stall
        add_vec(1, 5'd4,  5'd2,  1, 5'd15, 1, 0, 0, 2'b00, 2'b00, 0, 16'd1); // held, bubble in EX
        add_vec(0, 5'd0,  5'd0,  0, 5'd0,  0, 0, 0, 2'b01, 2'b00, 0, 16'd1); // add in EX: WB fwd
        add_vec(1, 5'd1,  5'd0,  0, 5'd0,  1, 1, 0, 2'b00, 2'b00, 0, 16'd1); // lw r0
        add_vec(1, 5'd0,  5'd0,  1, 5'd16, 1, 0, 0, 2'b00, 2'b00, 0, 16'd1); // use r0: no stall
        add_vec(1, 5'd1,  5'd0,  0, 5'd9,  1, 1, 0, 2'b00, 2'b00, 0, 16'd1); // lw r9; r0 no fwd
        add_vec(1, 5'd9,  5'd2,  1, 5'd17, 1, 0, 1, 2'b00, 2'b00, 0, 16'd1); // hazard + flush
        add_vec(0, 5'd0,  5'd0,  0, 5'd0,  0, 0, 0, 2'b00, 2'b00, 0, 16'd1); // flushed bubble
        add_vec(1, 5'd1,  5'd0,  0, 5'd20, 1, 1, 0, 2'b00, 2'b00, 0, 16'd1); // lw r20
        add_vec(1, 5'd3,  5'd20, 1, 5'd21, 1, 0, 0, 2'b00, 2'b00, 1, 16'd1); // rt=r20: stall
        add_vec(1, 5'd3,  5'd20, 1, 5'd21, 1, 0, 0, 2'b00, 2'b00, 0, 16'd2); // held
        add_vec(0, 5'd0,  5'd0,  0, 5'd0,  0, 0, 0, 2'b00, 2'b01, 0, 16'd2); // WB fwd b

        // Outputs held at zero while in reset
        #12;
        check("rst_stall", {15'd0, stall}, 16'd0);
        check("rst_count", stall_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: each entry is driven for one cycle and its expectation queued
        monitor_on = 1;
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            sb.push_back(vecs[i]);
        end
        begin
            int budget = 20;
            while (sb.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (sb.size() > 0) check("scoreboard_drain", 16'(sb.size()), 16'd0);
        end
        monitor_on = 0;

        // Async reset mid-stall: lw r4 then dependent add, then reset between edges
        @(posedge clk); #1;
        drive('{1'b1, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0});
        @(posedge clk); #1;
        drive('{1'b1, 5'd4, 5'd2, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0});
        @(negedge clk);
        check("pre_rst_stall", {15'd0, stall}, 16'd1);
        check("pre_rst_count", stall_count, 16'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_stall", {15'd0, stall}, 16'd0);
        check("async_rst_count", stall_count, 16'd0);
        check("async_rst_fa", {14'd0, forward_a}, 16'd0);
        check("async_rst_fb", {14'd0, forward_b}, 16'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_stall", {15'd0, stall}, 16'd0);
        check("post_rst_count", stall_count, 16'd0);
        check("post_rst_fa", {14'd0, forward_a}, 16'd0);
        @(posedge clk); #1;
        drive(idle);

        // Saturation on the low-limit instance: repeated load-use pairs
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            s_valid = 1'b1; s_rs = 5'd1; s_dest = 5'd4; s_memread = 1'b1;
            @(posedge clk); #1;
            s_rs = 5'd4; s_dest = 5'd15; s_memread = 1'b0;
            @(negedge clk);
            check("sat_stall", {15'd0, s_stall}, 16'd1);
            @(posedge clk); #1;
            @(negedge clk);
            check("sat_no_restall", {15'd0, s_stall}, 16'd0);
            check("sat_count", s_count, (k + 1 < 5) ? 16'(k + 1) : 16'd5);
        end
        s_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
